viewport_transform: RTL and testbench
=====================================

VIEWPORT_TRANSFORM -- requirements
Module: viewport_transform

Interface
REQ-001 SHALL have parameter WIDTH, default 320: screen width in pixels.
REQ-002 SHALL have parameter HEIGHT, default 180: screen height in pixels.
REQ-003 SHALL have port clk_in, input, 1: the only clock.
REQ-004 SHALL have port rst_in, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port valid_in, input, 1: vertex_in is valid this cycle. There is no backpressure.
REQ-006 SHALL have port vertex_in, input, [3:0][31:0]: fp32 NDC vertex {x, y, z, 1/w}; element 0 is x, element 3 is 1/w.
REQ-007 SHALL have port valid_out, input/output direction output, 1: outputs are valid this cycle.
REQ-008 SHALL have port x_out, output, 16: pixel column, unsigned.
REQ-009 SHALL have port y_out, output, 16: pixel row, unsigned, row 0 at top.
REQ-010 SHALL have port z_out, output, 16: depth, unsigned, 0 is near.
REQ-011 SHALL have port clipped_out, output, 1: vertex lies outside the view volume or is invalid.
REQ-012 SHALL have port index_out, output, 2: position of the vertex in its triangle (0, 1, 2).
REQ-013 SHALL have port tri_last_out, output, 1: high when index_out==2.

Function
REQ-014 SHALL be fully pipelined: accepts one vertex per cycle, fixed latency of 3 cycles from valid_in to valid_out; valid_out SHALL equal valid_in delayed by 3 cycles.
REQ-015 Stage 1 SHALL convert x, y, z to signed fixed-point f = trunc(v*2^16), 18 bits signed:
  - exponent e = 255 (inf/NaN): saturate by sign.
  - e < 111: f = 0.
  - e >= 128 (|v| >= 2): saturate to +131071 or -131072 by sign.
  - otherwise: f = ±({1,mantissa} shifted by e-134).
REQ-016 Stage 1 SHALL flag a component out of range when |v| > 1.0, i.e. e >= 128, or e == 127 with mantissa != 0, or e == 255.
REQ-017 Stage 2 SHALL compute the products:
  - px = (f_x + 65536) * WIDTH
  - py = (65536 - f_y) * HEIGHT
  - pz = (f_z + 65536) * 65535
  - Intermediates SHALL be wide enough that no product overflows.
REQ-018 Stage 3 SHALL right-shift each product by 17 and clamp:
  - x to [0, WIDTH-1]
  - y to [0, HEIGHT-1]
  - z to [0, 65535]
  - A negative intermediate SHALL clamp to 0.
REQ-019 clipped_out SHALL be the OR of:
  - any out-of-range flag for x, y or z;
  - the 1/w sign bit set;
  - 1/w equal to ±0;
  - 1/w exponent equal to 255.
REQ-020 A 2-bit vertex counter SHALL advance 0→1→2→0 on each cycle with valid_in high and hold otherwise.
REQ-021 The counter value captured with a vertex SHALL travel through the pipeline with it and appear on index_out.
REQ-022 Cycles with valid_in low SHALL insert bubbles; data outputs in bubble cycles are don't-care, but valid_out SHALL be 0.
REQ-023 Counter value 3 is unreachable and SHALL be treated as 0 if entered.

Reset
REQ-024 On rst_in high at a clock edge:
  - all pipeline valid bits SHALL clear and the vertex counter SHALL be 0;
  - valid_out, x_out, y_out, z_out, clipped_out, index_out and tri_last_out SHALL read 0 from the next cycle;
  - a valid_in asserted in the same cycle as rst_in SHALL be discarded.
REQ-025 Vertices in flight when reset asserts SHALL never produce valid_out.
REQ-026 The first vertex accepted after reset SHALL carry index 0.

Verification
REQ-027 Vertex {0.0, 0.0, 0.0, 1.0} (0x00000000 ×3, 0x3F800000) → 3 cycles later: valid_out=1, x_out=160, y_out=90, z_out=32767, clipped_out=0, index_out=0.
REQ-028 Vertex {1.0, -1.0, 1.0, 1.0} (0x3F800000, 0xBF800000, 0x3F800000, 0x3F800000) → x_out=319, y_out=179, z_out=65535, clipped_out=0. Vertex {-1.0, 1.0, -1.0, 1.0} → x_out=0, y_out=0, z_out=0, clipped_out=0.
REQ-029 Clipping cases:
  - x=2.0 (0x40000000) → x_out=319, clipped_out=1.
  - x=NaN (0x7FC00000) → clipped_out=1.
  - 1/w=-1.0 (0xBF800000) with x=y=z=0 → clipped_out=1.
REQ-030 Seven back-to-back valid vertices → valid_out high for 7 consecutive cycles; index_out sequence 0,1,2,0,1,2,0; tri_last_out high on the 3rd and 6th.
REQ-031 Valid pattern 1,0,1,1 → valid_out pattern 1,0,1,1 delayed exactly 3 cycles; indices 0,1,2.
REQ-032 Reset mid-operation:
  - Assert valid_in for two cycles, then rst_in for one cycle while the two vertices are in flight → no valid_out appears.
  - Next accepted vertex → index_out=0.

Source files
------------

// File: rtl/viewport_transform_if.sv
// Vertex-in / pixel-out bundle for the viewport transform.
// The DUT takes the slave view and the vertex source takes the master view.
interface viewport_transform_if;
    localparam int unsigned COORD_W = 16;
    localparam int unsigned IDX_W   = 2;

    logic                      valid_in;
    logic [3:0][31:0]          vertex_in;
    logic                      valid_out;
    logic [COORD_W-1:0]        x_out;
    logic [COORD_W-1:0]        y_out;
    logic [COORD_W-1:0]        z_out;
    logic                      clipped_out;
    logic [IDX_W-1:0]          index_out;
    logic                      tri_last_out;

    modport master (
        output valid_in, vertex_in,
        input  valid_out, x_out, y_out, z_out, clipped_out, index_out, tri_last_out
    );

    modport slave (
        input  valid_in, vertex_in,
        output valid_out, x_out, y_out, z_out, clipped_out, index_out, tri_last_out
    );
endinterface

// File: rtl/viewport_transform.sv
// Three-stage viewport transform: fp32 NDC vertex -> pixel x/y, 16-bit depth, clip flag.
// Stages: fp32 to 16.16 fixed point, scale multiply, shift and clamp.
module viewport_transform #(
    parameter int unsigned WIDTH  = 320,
    parameter int unsigned HEIGHT = 180
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    viewport_transform_if.slave  bus
);
    localparam int unsigned FW    = 18;
    localparam int unsigned PW    = 48;
    localparam int unsigned OW    = 16;
    localparam int unsigned SHIFT = 17;

    localparam logic signed [PW-1:0] ONE_FIX = PW'(65536);
    localparam logic signed [PW-1:0] X_SCALE = PW'(WIDTH);
    localparam logic signed [PW-1:0] Y_SCALE = PW'(HEIGHT);
    localparam logic signed [PW-1:0] Z_SCALE = PW'(65535);
    localparam logic signed [PW-1:0] X_MAX   = PW'(WIDTH - 1);
    localparam logic signed [PW-1:0] Y_MAX   = PW'(HEIGHT - 1);
    localparam logic signed [PW-1:0] Z_MAX   = PW'(65535);

    // Returns {out_of_range, trunc(v * 2^16) as 18-bit signed}.
    function automatic logic [FW:0] to_fix(input logic [31:0] v);
        logic          sign;
        logic [7:0]    e;
        logic [22:0]   m;
        logic [23:0]   mag24;
        logic [FW-1:0] mag;
        logic [FW-1:0] f;
        logic          oor;
        sign  = v[31];
        e     = v[30:23];
        m     = v[22:0];
        mag24 = {1'b1, m} >> (8'd134 - e);
        mag   = FW'(mag24);
        if (e >= 8'd128) begin
            f = sign ? 18'h20000 : 18'h1FFFF;
        end else if (e < 8'd111) begin
            f = '0;
        end else begin
            f = sign ? ((~mag) + FW'(1)) : mag;
        end
        oor = (e >= 8'd128) || ((e == 8'd127) && (m != '0));
        return {oor, f};
    endfunction

    // Arithmetic shift by 17, negative results pin to 0, large ones to hi.
    function automatic logic [OW-1:0] clamp(input logic signed [PW-1:0] p,
                                            input logic signed [PW-1:0] hi);
        logic signed [PW-1:0] s;
        s = p >>> SHIFT;
        if (s[PW-1]) begin
            return '0;
        end else if (s > hi) begin
            return OW'(hi);
        end else begin
            return OW'(s);
        end
    endfunction

    logic [1:0]           cnt;
    logic [1:0]           cnt_idx_c;
    logic [FW:0]          cx_c, cy_c, cz_c;
    logic [31:0]          w_c;
    logic                 clip_c;

    logic                 s1_valid;
    logic signed [FW-1:0] s1_fx, s1_fy, s1_fz;
    logic                 s1_clip;
    logic [1:0]           s1_idx;

    logic signed [PW-1:0] px_c, py_c, pz_c;

    logic                 s2_valid;
    logic signed [PW-1:0] s2_px, s2_py, s2_pz;
    logic                 s2_clip;
    logic [1:0]           s2_idx;

    // Stage 1 conversion and clip decision.
    always_comb begin
        cx_c      = to_fix(bus.vertex_in[0]);
        cy_c      = to_fix(bus.vertex_in[1]);
        cz_c      = to_fix(bus.vertex_in[2]);
        w_c       = bus.vertex_in[3];
        clip_c    = cx_c[FW] | cy_c[FW] | cz_c[FW]
                  | w_c[31]
                  | (w_c[30:0] == 31'd0)
                  | (w_c[30:23] == 8'hFF);
        cnt_idx_c = (cnt == 2'd3) ? 2'd0 : cnt;
    end

    // Vertex position counter, wraps 0 -> 1 -> 2 -> 0.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            cnt <= 2'd0;
        end else if (bus.valid_in) begin
            cnt <= (cnt_idx_c == 2'd2) ? 2'd0 : cnt_idx_c + 2'd1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= bus.valid_in;
        end
        s1_fx   <= cx_c[FW-1:0];
        s1_fy   <= cy_c[FW-1:0];
        s1_fz   <= cz_c[FW-1:0];
        s1_clip <= clip_c;
        s1_idx  <= cnt_idx_c;
    end

    // Stage 2 scale products; 48 bits covers 196607 * 65535 with margin.
    always_comb begin
        px_c = (PW'(s1_fx) + ONE_FIX) * X_SCALE;
        py_c = (ONE_FIX - PW'(s1_fy)) * Y_SCALE;
        pz_c = (PW'(s1_fz) + ONE_FIX) * Z_SCALE;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
        end
        s2_px   <= px_c;
        s2_py   <= py_c;
        s2_pz   <= pz_c;
        s2_clip <= s1_clip;
        s2_idx  <= s1_idx;
    end

    // Stage 3 output registers.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            bus.valid_out    <= 1'b0;
            bus.x_out        <= '0;
            bus.y_out        <= '0;
            bus.z_out        <= '0;
            bus.clipped_out  <= 1'b0;
            bus.index_out    <= '0;
            bus.tri_last_out <= 1'b0;
        end else begin
            bus.valid_out    <= s2_valid;
            bus.x_out        <= clamp(s2_px, X_MAX);
            bus.y_out        <= clamp(s2_py, Y_MAX);
            bus.z_out        <= clamp(s2_pz, Z_MAX);
            bus.clipped_out  <= s2_clip;
            bus.index_out    <= s2_idx;
            bus.tri_last_out <= (s2_idx == 2'd2);
        end
    end
endmodule

// File: tb/tb_viewport_transform.sv
// Directed bench for viewport_transform with hand-computed pixel/depth results.
module tb_viewport_transform;
    localparam logic [31:0] ZR    = 32'h0000_0000;
    localparam logic [31:0] P1    = 32'h3F80_0000;
    localparam logic [31:0] N1    = 32'hBF80_0000;
    localparam logic [31:0] HALF  = 32'h3F00_0000;
    localparam logic [31:0] NHALF = 32'hBF00_0000;
    localparam logic [31:0] TWO   = 32'h4000_0000;
    localparam logic [31:0] QNAN  = 32'h7FC0_0000;
    localparam logic [31:0] TINY  = 32'h3380_0000;
    localparam logic [31:0] OVER1 = 32'h3F80_0001;

    typedef struct {
        logic        v;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] z;
        logic        c;
        logic [1:0]  i;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    exp_t pipe [3];

    viewport_transform_if vif ();

    viewport_transform #(.WIDTH(320), .HEIGHT(180)) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (vif.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the expectation pipe, check outputs after the edge.
    task automatic tick(input logic r, input logic v,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] z, input logic [31:0] w,
                        input logic [15:0] ex, input logic [15:0] ey, input logic [15:0] ez,
                        input logic ec, input logic [1:0] ei);
        exp_t e;
        rst           = r;
        vif.valid_in  = v;
        vif.vertex_in = {w, z, y, x};
        e.v = v && !r;
        e.x = ex;
        e.y = ey;
        e.z = ez;
        e.c = ec;
        e.i = ei;
        if (r) begin
            for (int k = 0; k < 3; k++) pipe[k].v = 1'b0;
        end
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = e;
        @(posedge clk);
        @(negedge clk);
        check("valid_out", 32'(vif.valid_out), 32'(pipe[2].v));
        if (r) begin
            check("rst_x", 32'(vif.x_out), 32'd0);
            check("rst_y", 32'(vif.y_out), 32'd0);
            check("rst_z", 32'(vif.z_out), 32'd0);
            check("rst_clip", 32'(vif.clipped_out), 32'd0);
            check("rst_idx", 32'(vif.index_out), 32'd0);
            check("rst_tri", 32'(vif.tri_last_out), 32'd0);
        end else if (pipe[2].v) begin
            check("x_out", 32'(vif.x_out), 32'(pipe[2].x));
            check("y_out", 32'(vif.y_out), 32'(pipe[2].y));
            check("z_out", 32'(vif.z_out), 32'(pipe[2].z));
            check("clipped_out", 32'(vif.clipped_out), 32'(pipe[2].c));
            check("index_out", 32'(vif.index_out), 32'(pipe[2].i));
            check("tri_last_out", 32'(vif.tri_last_out), 32'(pipe[2].i == 2'd2));
        end
    endtask

    task automatic vtx(input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] z, input logic [31:0] w,
                       input logic [15:0] ex, input logic [15:0] ey, input logic [15:0] ez,
                       input logic ec, input logic [1:0] ei);
        tick(1'b0, 1'b1, x, y, z, w, ex, ey, ez, ec, ei);
    endtask

    task automatic bubble(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 1'b0, ZR, ZR, ZR, ZR, 16'd0, 16'd0, 16'd0, 1'b0, 2'd0);
    endtask

    task automatic reset_tick(input logic v);
        tick(1'b1, v, P1, P1, P1, P1, 16'd0, 16'd0, 16'd0, 1'b0, 2'd0);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) pipe[k] = '{1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 2'd0};
        vif.valid_in  = 1'b0;
        vif.vertex_in = '0;

        // Reset, with a vertex offered during reset that must be dropped.
        reset_tick(1'b0);
        reset_tick(1'b1);

        // Seven back-to-back vertices: centre, corners, clipping cases.
        vtx(ZR,    ZR, ZR, P1, 16'd160, 16'd90,  16'd32767, 1'b0, 2'd0);
        vtx(P1,    N1, P1, P1, 16'd319, 16'd179, 16'd65535, 1'b0, 2'd1);
        vtx(N1,    P1, N1, P1, 16'd0,   16'd0,   16'd0,     1'b0, 2'd2);
        vtx(TWO,   ZR, ZR, P1, 16'd319, 16'd90,  16'd32767, 1'b1, 2'd0);
        vtx(QNAN,  ZR, ZR, P1, 16'd319, 16'd90,  16'd32767, 1'b1, 2'd1);
        vtx(ZR,    ZR, ZR, N1, 16'd160, 16'd90,  16'd32767, 1'b1, 2'd2);
        vtx(ZR,    ZR, ZR, P1, 16'd160, 16'd90,  16'd32767, 1'b0, 2'd0);
        bubble(3);

        // Fresh counter, valid pattern 1,0,1,1 with fractional and edge values.
        reset_tick(1'b0);
        vtx(HALF,  HALF,  HALF,  P1, 16'd240, 16'd45,  16'd49151, 1'b0, 2'd0);
        bubble(1);
        vtx(NHALF, NHALF, NHALF, P1, 16'd80,  16'd135, 16'd16383, 1'b0, 2'd1);
        vtx(TINY,  OVER1, ZR,    P1, 16'd160, 16'd0,   16'd32767, 1'b1, 2'd2);
        bubble(3);

        // Reset with two vertices in flight; neither may emerge.
        vtx(ZR, ZR, ZR, P1, 16'd160, 16'd90, 16'd32767, 1'b0, 2'd0);
        vtx(P1, N1, P1, P1, 16'd319, 16'd179, 16'd65535, 1'b0, 2'd1);
        reset_tick(1'b0);
        bubble(3);

        // First vertex after reset carries index 0; 1/w = +0 clips.
        vtx(ZR, ZR, ZR, ZR, 16'd160, 16'd90, 16'd32767, 1'b1, 2'd0);
        bubble(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
